sysid_regs: RTL and testbench

Parametrised successor to the constant system-ID slave. It is an Avalon-MM register slave on the Nios system interconnect that exposes the build ID, timestamp and version as constants. It adds a byte-writable scratch register, a free-running uptime counter read atomically through a snapshot shadow, and a configurable fixed read latency. Software uses it to identify the hardware build and to timestamp events without a separate timer.

---
 rtl/sysid_regs_pkg.sv | 21 ++
 rtl/sysid_regs_if.sv | 26 ++
 rtl/sysid_uptime_counter.sv | 30 +++
 rtl/sysid_regs.sv | 132 +++++++++++++
 tb/tb_sysid_regs.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sysid_regs_pkg.sv
// sysid_regs shared definitions.
// Register map, control bits and the read pipeline stage type.
package sysid_regs_pkg;

    localparam logic [2:0] ADDR_ID        = 3'd0;
    localparam logic [2:0] ADDR_TIMESTAMP = 3'd1;
    localparam logic [2:0] ADDR_VERSION   = 3'd2;
    localparam logic [2:0] ADDR_SCRATCH   = 3'd3;
    localparam logic [2:0] ADDR_UPTIME_LO = 3'd4;
    localparam logic [2:0] ADDR_UPTIME_HI = 3'd5;
    localparam logic [2:0] ADDR_CONTROL   = 3'd6;

    localparam int CTRL_CLEAR_BIT  = 0;
    localparam int CTRL_FREEZE_BIT = 1;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
    } rd_stage_t;

endpackage

// File: rtl/sysid_regs_if.sv
// Avalon-MM slave bundle for sysid_regs.
// Master drives requests, slave returns pipelined read data.
interface sysid_regs_if;

    logic [2:0]  address;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        readdatavalid;

    modport master (
        output address, chipselect, read, write,
        output writedata, byteenable,
        input  readdata, readdatavalid
    );

    modport slave (
        input  address, chipselect, read, write,
        input  writedata, byteenable,
        output readdata, readdatavalid
    );

endinterface

// File: rtl/sysid_uptime_counter.sv
// Free-running uptime counter with clear and freeze.
// Clear wins over freeze; the count wraps at full width.
module sysid_uptime_counter #(
    parameter int UPTIME_WIDTH = 64
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    i_clear,
    input  logic                    i_freeze,
    output logic [UPTIME_WIDTH-1:0] o_count
);

    localparam logic [UPTIME_WIDTH-1:0] ONE = UPTIME_WIDTH'(1);

    logic [UPTIME_WIDTH-1:0] r_count;

    // Count every cycle unless frozen; clear forces zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (!i_freeze) begin
            r_count <= r_count + ONE;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/sysid_regs.sv
// System-ID register slave: constants, scratch, uptime with
// snapshot shadow, and a fixed read-latency pipeline.
module sysid_regs
    import sysid_regs_pkg::*;
#(
    parameter logic [31:0] SYSTEM_ID    = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP    = 32'h0000_0000,
    parameter logic [31:0] VERSION      = 32'h0001_0000,
    parameter int          UPTIME_WIDTH = 64,
    parameter int          READ_LATENCY = 1
) (
    input  logic         clock,
    input  logic         reset_n,
    sysid_regs_if.slave  bus
);

    logic                    w_rd_acc;
    logic                    w_wr_acc;
    logic                    w_clear;
    logic [UPTIME_WIDTH-1:0] w_count;
    logic [31:0]             w_rdata;
    rd_stage_t               w_stage0;
    rd_stage_t               w_last;

    logic [31:0] r_scratch;
    logic        r_freeze;
    logic [31:0] r_shadow;
    logic [31:0] r_rdata;
    logic        r_rdv;

    // A write in the same cycle as a read wins; the read is dropped.
    assign w_wr_acc = bus.chipselect & bus.write;
    assign w_rd_acc = bus.chipselect & bus.read & ~bus.write;

    assign w_clear = w_wr_acc
                   & (bus.address == ADDR_CONTROL)
                   & bus.writedata[CTRL_CLEAR_BIT];

    sysid_uptime_counter #(
        .UPTIME_WIDTH (UPTIME_WIDTH)
    ) u_cnt (
        .clock    (clock),
        .reset_n  (reset_n),
        .i_clear  (w_clear),
        .i_freeze (r_freeze),
        .o_count  (w_count)
    );

    // Read mux, sampled at acceptance.
    always_comb begin
        w_rdata = '0;
        unique case (bus.address)
            ADDR_ID:        w_rdata = SYSTEM_ID;
            ADDR_TIMESTAMP: w_rdata = TIMESTAMP;
            ADDR_VERSION:   w_rdata = VERSION;
            ADDR_SCRATCH:   w_rdata = r_scratch;
            ADDR_UPTIME_LO: w_rdata = w_count[31:0];
            ADDR_UPTIME_HI: w_rdata = r_shadow;
            ADDR_CONTROL:   begin
                w_rdata = '0;
                w_rdata[CTRL_FREEZE_BIT] = r_freeze;
            end
            default:        w_rdata = '0;
        endcase
    end

    // SCRATCH byte lanes and the CONTROL freeze bit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_scratch <= '0;
            r_freeze  <= 1'b0;
        end else if (w_wr_acc) begin
            if (bus.address == ADDR_SCRATCH) begin
                for (int i = 0; i < 4; i++) begin
                    if (bus.byteenable[i]) begin
                        r_scratch[8*i +: 8] <= bus.writedata[8*i +: 8];
                    end
                end
            end
            if (bus.address == ADDR_CONTROL) begin
                r_freeze <= bus.writedata[CTRL_FREEZE_BIT];
            end
        end
    end

    // Reading UPTIME_LO latches the upper count bits for UPTIME_HI.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_shadow <= '0;
        end else if (w_rd_acc && bus.address == ADDR_UPTIME_LO) begin
            r_shadow <= 32'(w_count >> 32);
        end
    end

    assign w_stage0 = '{valid: w_rd_acc, data: w_rdata};

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            rd_stage_t r_stage;

            // Extra delay stage for two-cycle latency.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    r_stage <= '0;
                end else begin
                    r_stage <= w_stage0;
                end
            end

            assign w_last = r_stage;
        end else begin : g_lat1
            assign w_last = w_stage0;
        end
    endgenerate

    // Output stage: valid pulses once, data holds between reads.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rdv   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_rdv <= w_last.valid;
            if (w_last.valid) begin
                r_rdata <= w_last.data;
            end
        end
    end

    assign bus.readdata      = r_rdata;
    assign bus.readdatavalid = r_rdv;

endmodule

// File: tb/tb_sysid_regs.sv
// Randomized scoreboard bench for sysid_regs.
// A cycle-level register model predicts every read response.
module tb_sysid_regs;

    localparam logic [31:0] P_ID  = 32'hA5A5_0001;
    localparam logic [31:0] P_TS  = 32'd1523669924;
    localparam logic [31:0] P_VER = 32'h0001_0000;
    localparam int          P_LAT = 2;

    logic clock;
    logic reset_n;

    sysid_regs_if bus();

    sysid_regs #(
        .SYSTEM_ID    (P_ID),
        .TIMESTAMP    (P_TS),
        .VERSION      (P_VER),
        .UPTIME_WIDTH (64),
        .READ_LATENCY (P_LAT)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference state
    logic [31:0] m_scratch;
    logic        m_freeze;
    logic [63:0] m_cnt;
    logic [31:0] m_shadow;
    logic [31:0] m_last;

    function automatic logic [31:0] model_read(input logic [2:0] a);
        case (a)
            3'd0:    return P_ID;
            3'd1:    return P_TS;
            3'd2:    return P_VER;
            3'd3:    return m_scratch;
            3'd4:    return m_cnt[31:0];
            3'd5:    return m_shadow;
            3'd6:    return m_freeze ? 32'h2 : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    // Model: sample the request at each edge and advance state.
    always @(posedge clock) begin
        int   acc;
        logic rd_ok;
        logic wr_ok;
        logic clr;
        exp_t e;
        acc = cyc;
        cyc = cyc + 1;
        if (!reset_n) begin
            m_scratch = '0;
            m_freeze  = 1'b0;
            m_cnt     = '0;
            m_shadow  = '0;
            exp_q.delete();
        end else begin
            rd_ok = bus.chipselect && bus.read && !bus.write;
            wr_ok = bus.chipselect && bus.write;
            if (rd_ok) begin
                e.data = model_read(bus.address);
                e.due  = acc + P_LAT;
                exp_q.push_back(e);
                if (bus.address == 3'd4) m_shadow = m_cnt[63:32];
            end
            clr = wr_ok && bus.address == 3'd6 && bus.writedata[0];
            if (wr_ok && bus.address == 3'd3) begin
                for (int i = 0; i < 4; i++)
                    if (bus.byteenable[i])
                        m_scratch[8*i +: 8] = bus.writedata[8*i +: 8];
            end
            if (clr)            m_cnt = '0;
            else if (!m_freeze) m_cnt = m_cnt + 64'd1;
            if (wr_ok && bus.address == 3'd6) m_freeze = bus.writedata[1];
        end
    end

    // Monitor: compare DUT outputs mid-cycle against the queue.
    always @(negedge clock) begin
        exp_t e;
        if (!reset_n) begin
            exp_q.delete();
            m_last = '0;
            n_cmp++;
            if (bus.readdatavalid !== 1'b0 || bus.readdata !== 32'h0) begin
                n_bad++;
                $display("FAIL reset_out: rdv=%b data=%h, want rdv=0 data=0",
                         bus.readdatavalid, bus.readdata);
            end
        end else if (bus.readdatavalid === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_valid: cyc=%0d data=%h, want no pulse",
                         cyc, bus.readdata);
            end else begin
                e = exp_q.pop_front();
                m_last = e.data;
                if (e.due != cyc || bus.readdata !== e.data) begin
                    n_bad++;
                    $display("FAIL read_data: cyc=%0d data=%h, want cyc=%0d data=%h",
                             cyc, bus.readdata, e.due, e.data);
                end
            end
        end else begin
            if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                e = exp_q.pop_front();
                n_cmp++;
                n_bad++;
                $display("FAIL missing_valid: cyc=%0d rdv=0, want pulse data=%h",
                         cyc, e.data);
            end
            n_cmp++;
            if (bus.readdata !== m_last) begin
                n_bad++;
                $display("FAIL data_hold: readdata=%h, want held %h",
                         bus.readdata, m_last);
            end
        end
    end

    task automatic bus_op(input logic c, input logic r, input logic w,
                          input logic [2:0] a, input logic [31:0] d,
                          input logic [3:0] be);
        bus.chipselect = c;
        bus.read       = r;
        bus.write      = w;
        bus.address    = a;
        bus.writedata  = d;
        bus.byteenable = be;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus_op(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
    endtask

    task automatic rd(input logic [2:0] a);
        bus_op(1'b1, 1'b1, 1'b0, a, 32'h0, 4'h0);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d,
                      input logic [3:0] be);
        bus_op(1'b1, 1'b0, 1'b1, a, d, be);
    endtask

    initial begin
        int op;
        reset_n        = 1'b0;
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        bus.write      = 1'b0;
        bus.address    = '0;
        bus.writedata  = '0;
        bus.byteenable = '0;
        m_last         = '0;
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        idle(2);

        // Constants and the unmapped address, back to back
        rd(3'd0); rd(3'd1); rd(3'd2); rd(3'd7);
        rd(3'd3); rd(3'd5); rd(3'd6);
        idle(4);

        // Scratch byte enables
        wr(3'd3, 32'hDEAD_BEEF, 4'b1111);
        wr(3'd3, 32'h1122_3344, 4'b0101);
        rd(3'd3);
        idle(3);

        // Clear + freeze, then release
        wr(3'd6, 32'h3, 4'h0);
        idle(100);
        rd(3'd4); rd(3'd6);
        wr(3'd6, 32'h0, 4'h0);
        idle(5);
        rd(3'd4);
        idle(3);

        // Simultaneous read and write: write only
        bus_op(1'b1, 1'b1, 1'b1, 3'd3, 32'h0000_00FF, 4'hF);
        idle(3);
        rd(3'd3);
        idle(3);

        // Snapshot atomicity across the 32-bit carry
        wr(3'd6, 32'h2, 4'h0);
        idle(1);
        force dut.u_cnt.r_count = 64'h0000_0000_FFFF_FFFF;
        m_cnt = 64'h0000_0000_FFFF_FFFF;
        @(posedge clock);
        #1;
        release dut.u_cnt.r_count;
        wr(3'd6, 32'h0, 4'h0);
        rd(3'd4);
        idle(5);
        rd(3'd5);
        idle(2);
        rd(3'd4); rd(3'd5);
        idle(3);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            op = $urandom_range(0, 9);
            bus_op(($urandom_range(0, 7) != 0),
                   (op <= 4) || (op == 8),
                   (op >= 5) && (op <= 8),
                   3'($urandom_range(0, 7)),
                   $urandom,
                   4'($urandom_range(0, 15)));
        end
        idle(4);

        // Reset with a read in flight
        rd(3'd0);
        reset_n        = 1'b0;
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        idle(3);
        reset_n = 1'b1;
        idle(5);
        rd(3'd3); rd(3'd4); rd(3'd5); rd(3'd6);

        // Drain with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) idle(1);
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d reads pending, want 0", exp_q.size());
        end
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
